ble_lut6: RTL and testbench

- Basic Logic Element (BLE) for an FPGA-style fabric. It contains a 6-input LUT, an optional output flip-flop, and a 65-bit serial configuration shift chain.
- The chain holds 64 LUT truth-table bits plus 1 output-select bit.
- config_out lets multiple BLEs be daisy-chained into one configuration scan path.
- Instantiated inside a CLB next to the routing muxes.

---
 rtl/ble_lut6_pkg.sv | 25 ++
 rtl/ble_lut6_if.sv | 35 +++
 rtl/ble_lut6_cfg_shift_chain.sv | 57 +++++
 rtl/ble_lut6.sv | 78 +++++++
 tb/tb_ble_lut6.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/ble_lut6_pkg.sv
// Shared constants and types for the ble_lut6 logic element.
// Optional feature macro used by this codebase slice: BLE_LUT_OUT_EN.
package ble_pkg;

  localparam int BLE_K        = 6;
  localparam int BLE_LUT_BITS = 64;
  localparam int BLE_CFG_W    = 65;
  localparam int BLE_SEL_BIT  = 64;

  typedef enum logic {
    OUT_COMB = 1'b0,
    OUT_REG  = 1'b1
  } out_mode_e;

  // Output-select chain bit to output mode.
  function automatic out_mode_e decode_mode(input logic sel);
    out_mode_e mode;
    case (sel)
      1'b1:    mode = OUT_REG;
      default: mode = OUT_COMB;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/ble_lut6_if.sv
// Data and configuration signals of one BLE, with master/slave views.
// BLE_LUT_OUT_EN adds the lut_out cascade tap.
interface ble_lut6_if
  import ble_pkg::*;
#(
  parameter int K = BLE_K
) ();

  logic         config_in;
  logic         config_clk;
  logic         config_en;
  logic         config_out;
  logic [K-1:0] data_in;
  logic         data_out;
`ifdef BLE_LUT_OUT_EN
  logic         lut_out;
`endif

  modport master (
    output config_in, config_clk, config_en, data_in,
`ifdef BLE_LUT_OUT_EN
    input  lut_out,
`endif
    input  config_out, data_out
  );

  modport slave (
    input  config_in, config_clk, config_en, data_in,
`ifdef BLE_LUT_OUT_EN
    output lut_out,
`endif
    output config_out, data_out
  );

endinterface

// File: rtl/ble_lut6_cfg_shift_chain.sv
// Configuration scan chain: strobe edge detect in the clk domain plus an
// enabled right-shift register whose LSB is the chain tail.
module cfg_shift_chain
  import ble_pkg::*;
#(
  parameter int CFG_W = BLE_CFG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             config_in_i,
  input  logic             config_clk_i,
  input  logic             config_en_i,
  output logic [CFG_W-1:0] cfg_o,
  output logic             config_out_o
);

  logic             cfg_clk_q;
  logic             cfg_clk_d;
  logic             shift_pulse_s;
  // Configuration is deliberately outside reset; power-up contents are zero.
  logic [CFG_W-1:0] cfg_q = '0;
  logic [CFG_W-1:0] cfg_d;

  // Rising-edge detect of the strobe, qualified by enable.
  always_comb begin
    cfg_clk_d     = config_clk_i;
    shift_pulse_s = config_clk_i & ~cfg_clk_q & config_en_i;
  end

  // Next chain contents: a strobe coinciding with reset is dropped.
  always_comb begin
    cfg_d = cfg_q;
    if (shift_pulse_s && !reset) begin
      cfg_d = {config_in_i, cfg_q[CFG_W-1:1]};
    end else begin
      cfg_d = cfg_q;
    end
  end

  // Strobe history register, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_clk_q <= 1'b0;
    end else begin
      cfg_clk_q <= cfg_clk_d;
    end
  end

  // Chain storage.
  always_ff @(posedge clk) begin
    cfg_q <= cfg_d;
  end

  assign cfg_o        = cfg_q;
  assign config_out_o = cfg_q[0];

endmodule

// File: rtl/ble_lut6.sv
// Basic logic element: 6-input LUT, optional output flip-flop, 65-bit scan chain.
// Define BLE_LUT_OUT_EN to expose the raw LUT output as bus.lut_out.
module ble_lut6
  import ble_pkg::*;
#(
  parameter int K = BLE_K
) (
  input  logic       clk,
  input  logic       reset,
  ble_lut6_if.slave  bus
);

  localparam int LUT_BITS = 2 ** K;
  localparam int CFG_W    = LUT_BITS + 1;
  localparam int SEL_BIT  = CFG_W - 1;

  logic [CFG_W-1:0]    cfg_s;
  logic [LUT_BITS-1:0] lut_bits_s;
  logic                config_out_s;
  logic                lut_s;
  logic                data_out_s;
  out_mode_e           mode_s;
  logic                ff_q;
  logic                ff_d;

  cfg_shift_chain #(
    .CFG_W (CFG_W)
  ) u_chain (
    .clk          (clk),
    .reset        (reset),
    .config_in_i  (bus.config_in),
    .config_clk_i (bus.config_clk),
    .config_en_i  (bus.config_en),
    .cfg_o        (cfg_s),
    .config_out_o (config_out_s)
  );

  // Truth-table lookup and output-mode decode.
  always_comb begin
    lut_bits_s = cfg_s[LUT_BITS-1:0];
    lut_s      = lut_bits_s[bus.data_in];
    mode_s     = decode_mode(cfg_s[SEL_BIT]);
  end

  // Flip-flop freezes while configuring so partial tables are never captured.
  always_comb begin
    ff_d = ff_q;
    if (bus.config_en) begin
      ff_d = ff_q;
    end else begin
      ff_d = lut_s;
    end
  end

  // Output flip-flop; reset wins over capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      ff_q <= 1'b0;
    end else begin
      ff_q <= ff_d;
    end
  end

  // Output select.
  always_comb begin
    case (mode_s)
      OUT_REG: data_out_s = ff_q;
      default: data_out_s = lut_s;
    endcase
  end

  assign bus.data_out   = data_out_s;
  assign bus.config_out = config_out_s;
`ifdef BLE_LUT_OUT_EN
  assign bus.lut_out    = lut_s;
`endif

endmodule

// File: tb/tb_ble_lut6.sv
// Scoreboard bench for ble_lut6: driver queues expected values, a negedge
// monitor pops and compares them. Honours BLE_LUT_OUT_EN when defined.
module tb_ble_lut6;
  import ble_pkg::*;

  localparam int SIG_DOUT = 0;
  localparam int SIG_COUT = 1;
  localparam int SIG_LOUT = 2;

  typedef struct {
    string name;
    int    sig;
    logic  exp;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  ble_lut6_if #(.K(BLE_K)) bus ();

  ble_lut6 #(.K(BLE_K)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input string name, input int sig, input logic exp);
    exp_t e;
    e.name = name;
    e.sig  = sig;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic b);
    bus.config_in  = b;
    bus.config_clk = 1'b1;
    tick();
    bus.config_clk = 1'b0;
    tick();
  endtask

  task automatic load(input logic [64:0] pat);
    bus.config_en = 1'b1;
    for (int i = 0; i < BLE_CFG_W; i++) strobe(pat[i]);
    bus.config_en = 1'b0;
    bus.config_in = 1'b0;
  endtask

  // Shift zeros in, checking the tail shows each old bit before its strobe.
  task automatic readback(input logic [64:0] pat, input string tag);
    bus.config_en = 1'b1;
    for (int k = 0; k < BLE_CFG_W; k++) begin
      push_exp($sformatf("%s_rb%0d", tag, k), SIG_COUT, pat[k]);
      strobe(1'b0);
    end
    bus.config_en = 1'b0;
  endtask

  // Monitor: compares every queued expectation against the live outputs.
  always @(negedge clk) begin : monitor
    exp_t e;
    logic act;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.sig)
        SIG_COUT: act = bus.config_out;
`ifdef BLE_LUT_OUT_EN
        SIG_LOUT: act = bus.lut_out;
`endif
        default:  act = bus.data_out;
      endcase
      n_checks++;
      if (act === e.exp) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete within 200000 time units");
    $fatal(1);
  end

  initial begin : driver
    logic [64:0] pat1;
    logic [64:0] pat2;
    logic [64:0] pat3;
    pat1 = '0;
    pat1[5] = 1'b1;
    pat2 = '0;
    pat2[63] = 1'b1;
    pat2[64] = 1'b1;
    pat3 = pat2;
    pat3[0] = 1'b1;

    bus.config_in  = 1'b0;
    bus.config_clk = 1'b0;
    bus.config_en  = 1'b0;
    bus.data_in    = 6'd0;
    reset = 1'b1;
    tick();
    tick();
    push_exp("rst_dout", SIG_DOUT, 1'b0);
    push_exp("rst_cout", SIG_COUT, 1'b0);
    tick();
    reset = 1'b0;
    tick();

    // Combinational mode, single minterm at address 5.
    load(pat1);
    for (int i = 0; i < BLE_LUT_BITS; i++) begin
      bus.data_in = 6'(i);
      push_exp($sformatf("t1_sweep%0d", i), SIG_DOUT, (i == 5) ? 1'b1 : 1'b0);
`ifdef BLE_LUT_OUT_EN
      push_exp($sformatf("t1_lut%0d", i), SIG_LOUT, (i == 5) ? 1'b1 : 1'b0);
`endif
      tick();
    end
    push_exp("t1_cout", SIG_COUT, 1'b0);

    // Registered mode: one edge of latency.
    bus.data_in = 6'd0;
    load(pat2);
    tick();
    bus.data_in = 6'd63;
    push_exp("t2_pre_edge", SIG_DOUT, 1'b0);
    tick();
    push_exp("t2_post_edge", SIG_DOUT, 1'b1);
    bus.data_in = 6'd0;
    push_exp("t2_hold", SIG_DOUT, 1'b1);
    tick();
    push_exp("t2_cleared", SIG_DOUT, 1'b0);
    push_exp("t2_cout", SIG_COUT, 1'b0);

    // Strobes with enable low must not disturb the chain.
    bus.config_in = 1'b1;
    for (int i = 0; i < BLE_CFG_W; i++) begin
      bus.config_clk = 1'b1;
      tick();
      bus.config_clk = 1'b0;
      tick();
    end
    bus.config_in = 1'b0;
    bus.data_in = 6'd63;
    tick();
    push_exp("t3_r63", SIG_DOUT, 1'b1);
    bus.data_in = 6'd0;
    tick();
    push_exp("t3_r0", SIG_DOUT, 1'b0);
    push_exp("t3_cout", SIG_COUT, 1'b0);

    // Readback of pat2; chain ends all zero.
    readback(pat2, "t4");
    bus.data_in = 6'd63;
    tick();
    push_exp("t4_dout", SIG_DOUT, 1'b0);
    push_exp("t4_cout", SIG_COUT, 1'b0);

    // Reset clears the flip-flop but not the configuration.
    bus.data_in = 6'd0;
    load(pat3);
    bus.data_in = 6'd63;
    tick();
    tick();
    push_exp("t5_pre_rst", SIG_DOUT, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    push_exp("t5_after_rst", SIG_DOUT, 1'b0);
    tick();
    push_exp("t5_recovered", SIG_DOUT, 1'b1);
    push_exp("t5_cout", SIG_COUT, 1'b1);

    // Strobe coincident with reset is dropped.
    bus.config_en  = 1'b1;
    bus.config_in  = 1'b0;
    reset          = 1'b1;
    bus.config_clk = 1'b1;
    tick();
    bus.config_clk = 1'b0;
    reset          = 1'b0;
    push_exp("t6_cout_now", SIG_COUT, 1'b1);
    tick();
    push_exp("t6_cout_later", SIG_COUT, 1'b1);
    readback(pat3, "t6");

    @(negedge clk);
    #1;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
